// File: rtl/bram_arbiter.sv
// Round-robin arbiter that shares one single-port BRAM between two requesters,
// with an optional bounded lock for atomic sequences and read-data return routing.
module bram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WEN_WIDTH  = (DATA_WIDTH + 7) / 8,
  parameter int RD_LATENCY = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  inj_rst,

  input  logic                  P0_Req,
  input  logic                  P0_Lock,
  input  logic [ADDR_WIDTH-1:0] P0_Addr,
  input  logic [DATA_WIDTH-1:0] P0_Din,
  input  logic [WEN_WIDTH-1:0]  P0_WEN,
  output logic                  P0_Gnt,
  output logic [DATA_WIDTH-1:0] P0_Dout,
  output logic                  P0_RdValid,

  input  logic                  P1_Req,
  input  logic                  P1_Lock,
  input  logic [ADDR_WIDTH-1:0] P1_Addr,
  input  logic [DATA_WIDTH-1:0] P1_Din,
  input  logic [WEN_WIDTH-1:0]  P1_WEN,
  output logic                  P1_Gnt,
  output logic [DATA_WIDTH-1:0] P1_Dout,
  output logic                  P1_RdValid,

  output logic [ADDR_WIDTH-1:0] O_Addr,
  output logic                  O_EN,
  output logic [DATA_WIDTH-1:0] O_Din,
  input  logic [DATA_WIDTH-1:0] O_Dout,
  output logic [WEN_WIDTH-1:0]  O_WEN,
  output logic                  O_Clk,
  output logic                  O_Rst
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    HOLD0 = 2'd1,
    HOLD1 = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  state_t                state, state_next;
  logic                  last_gnt, last_gnt_next;
  logic [7:0]            hold_cnt, hold_cnt_next, hold_cnt_inc;
  logic                  gnt0, gnt1;
  logic                  issue_read;
  logic [RD_LATENCY-1:0] rd_valid, rd_owner;
  logic                  exit_valid, exit_owner;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!Rst && !inj_rst) begin
      case (state)
        ARB: begin
          if (P0_Req && P1_Req) begin
            gnt0 = last_gnt;
            gnt1 = !last_gnt;
          end else begin
            gnt0 = P0_Req;
            gnt1 = P1_Req;
          end
        end
        HOLD0:   gnt0 = P0_Req;
        HOLD1:   gnt1 = P1_Req;
        default: ;
      endcase
    end
  end

  assign hold_cnt_inc = hold_cnt + 8'd1;

  // hold_cnt counts cycles owned, including the cycle the lock was taken;
  // reaching HOLD_LIMIT ends the hold and hands contention to the other port.
  always_comb begin
    state_next    = state;
    last_gnt_next = last_gnt;
    hold_cnt_next = hold_cnt;
    if (gnt0) begin
      last_gnt_next = 1'b0;
    end else if (gnt1) begin
      last_gnt_next = 1'b1;
    end
    if (inj_rst) begin
      state_next    = ARB;
      hold_cnt_next = '0;
    end else begin
      case (state)
        ARB: begin
          if (((gnt0 && P0_Lock) || (gnt1 && P1_Lock)) && HOLD_LIMIT != 8'd1) begin
            state_next    = gnt0 ? HOLD0 : HOLD1;
            hold_cnt_next = 8'd1;
          end
        end
        HOLD0: begin
          if (!P0_Lock) begin
            state_next    = ARB;
            hold_cnt_next = '0;
          end else if (hold_cnt_inc == HOLD_LIMIT) begin
            state_next    = ARB;
            hold_cnt_next = '0;
            last_gnt_next = 1'b0;
          end else begin
            hold_cnt_next = hold_cnt_inc;
          end
        end
        HOLD1: begin
          if (!P1_Lock) begin
            state_next    = ARB;
            hold_cnt_next = '0;
          end else if (hold_cnt_inc == HOLD_LIMIT) begin
            state_next    = ARB;
            hold_cnt_next = '0;
            last_gnt_next = 1'b1;
          end else begin
            hold_cnt_next = hold_cnt_inc;
          end
        end
        default: begin
          state_next    = ARB;
          hold_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= ARB;
      last_gnt <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      last_gnt <= last_gnt_next;
      hold_cnt <= hold_cnt_next;
    end
  end

  assign issue_read = (gnt0 && (P0_WEN == '0)) || (gnt1 && (P1_WEN == '0));

  // One slot per latency cycle; the last slot lines up with O_Dout.
  always_ff @(posedge Clk) begin
    if (Rst || inj_rst) begin
      rd_valid <= '0;
      rd_owner <= '0;
    end else begin
      rd_valid[0] <= issue_read;
      rd_owner[0] <= gnt1;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_valid[i] <= rd_valid[i-1];
        rd_owner[i] <= rd_owner[i-1];
      end
    end
  end

  assign exit_valid = rd_valid[RD_LATENCY-1] && !Rst;
  assign exit_owner = rd_owner[RD_LATENCY-1];

  assign P0_Gnt     = gnt0;
  assign P1_Gnt     = gnt1;
  assign P0_RdValid = exit_valid && !exit_owner;
  assign P1_RdValid = exit_valid && exit_owner;
  assign P0_Dout    = P0_RdValid ? O_Dout : '0;
  assign P1_Dout    = P1_RdValid ? O_Dout : '0;

  // An injected reset keeps the BRAM enabled so its own reset takes effect.
  always_comb begin
    O_EN   = 1'b0;
    O_Addr = '0;
    O_Din  = '0;
    O_WEN  = '0;
    if (!Rst) begin
      if (inj_rst) begin
        O_EN = 1'b1;
      end else if (gnt0) begin
        O_EN   = 1'b1;
        O_Addr = P0_Addr;
        O_Din  = P0_Din;
        O_WEN  = P0_WEN;
      end else if (gnt1) begin
        O_EN   = 1'b1;
        O_Addr = P1_Addr;
        O_Din  = P1_Din;
        O_WEN  = P1_WEN;
      end
    end
  end

  assign O_Clk = Clk;
  assign O_Rst = Rst || inj_rst;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: directed scenarios plus random traffic, every cycle
// compared against a cycle-level reference model with its own memory image.
module tb_bram_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int WW  = 4;
  localparam int LAT = 3;
  localparam int MH  = 4;

  logic          Clk = 1'b0;
  logic          Rst, inj_rst;
  logic          P0_Req, P0_Lock, P1_Req, P1_Lock;
  logic [AW-1:0] P0_Addr, P1_Addr, O_Addr;
  logic [DW-1:0] P0_Din, P1_Din, P0_Dout, P1_Dout, O_Din, O_Dout;
  logic [WW-1:0] P0_WEN, P1_WEN, O_WEN;
  logic          P0_Gnt, P1_Gnt, P0_RdValid, P1_RdValid;
  logic          O_EN, O_Clk, O_Rst;

  always #5 Clk = ~Clk;

  bram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WEN_WIDTH(WW),
    .RD_LATENCY(LAT), .MAX_HOLD(MH)
  ) dut (
    .Clk(Clk), .Rst(Rst), .inj_rst(inj_rst),
    .P0_Req(P0_Req), .P0_Lock(P0_Lock), .P0_Addr(P0_Addr), .P0_Din(P0_Din),
    .P0_WEN(P0_WEN), .P0_Gnt(P0_Gnt), .P0_Dout(P0_Dout), .P0_RdValid(P0_RdValid),
    .P1_Req(P1_Req), .P1_Lock(P1_Lock), .P1_Addr(P1_Addr), .P1_Din(P1_Din),
    .P1_WEN(P1_WEN), .P1_Gnt(P1_Gnt), .P1_Dout(P1_Dout), .P1_RdValid(P1_RdValid),
    .O_Addr(O_Addr), .O_EN(O_EN), .O_Din(O_Din), .O_Dout(O_Dout),
    .O_WEN(O_WEN), .O_Clk(O_Clk), .O_Rst(O_Rst)
  );

  // Behavioural BRAM with LAT cycles of read latency.
  logic [DW-1:0] mem  [256];
  logic [DW-1:0] pipe [LAT];

  always @(posedge Clk) begin
    if (O_EN) begin
      for (int b = 0; b < WW; b++)
        if (O_WEN[b]) mem[O_Addr[7:0]][8*b +: 8] <= O_Din[8*b +: 8];
      pipe[0] <= mem[O_Addr[7:0]];
    end
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign O_Dout = pipe[LAT-1];

  // Reference model state.
  typedef struct {
    int            owner;
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  rd_t           rdq[$];
  logic [DW-1:0] ref_mem [256];
  int            holder, held, last_win, cyc, model_win;
  int            compared, mismatched;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Predicts this cycle's outputs from the current inputs, compares, then
  // advances the model to the next cycle.
  task automatic checkCycle();
    bit            req [2], lock [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] din [2];
    logic [WW-1:0] wen [2];
    int            w = -1;
    bit            ev0 = 0, ev1 = 0, een = 0;
    logic [DW-1:0] ed0 = '0, ed1 = '0, edin = '0;
    logic [AW-1:0] eaddr = '0;
    logic [WW-1:0] ewen = '0;
    req[0] = P0_Req;   req[1] = P1_Req;
    lock[0] = P0_Lock; lock[1] = P1_Lock;
    addr[0] = P0_Addr; addr[1] = P1_Addr;
    din[0] = P0_Din;   din[1] = P1_Din;
    wen[0] = P0_WEN;   wen[1] = P1_WEN;

    if (!Rst && rdq.size() > 0 && rdq[0].due == cyc) begin
      if (rdq[0].owner == 0) begin ev0 = 1; ed0 = rdq[0].data; end
      else begin ev1 = 1; ed1 = rdq[0].data; end
      void'(rdq.pop_front());
    end

    if (Rst) begin
      holder = -1; last_win = 1; rdq.delete();
    end else if (inj_rst) begin
      een = 1; holder = -1; rdq.delete();
    end else begin
      if (holder >= 0) w = req[holder] ? holder : -1;
      else if (req[0] && req[1]) w = 1 - last_win;
      else if (req[0]) w = 0;
      else if (req[1]) w = 1;
      if (w >= 0) begin
        een = 1; eaddr = addr[w]; edin = din[w]; ewen = wen[w];
      end
    end

    checkOutput("gnt0", 64'(P0_Gnt), 64'(w == 0));
    checkOutput("gnt1", 64'(P1_Gnt), 64'(w == 1));
    checkOutput("o_en", 64'(O_EN), 64'(een));
    checkOutput("o_addr", 64'(O_Addr), 64'(eaddr));
    checkOutput("o_din", 64'(O_Din), 64'(edin));
    checkOutput("o_wen", 64'(O_WEN), 64'(ewen));
    checkOutput("o_rst", 64'(O_Rst), 64'(Rst | inj_rst));
    checkOutput("o_clk", 64'(O_Clk), 64'(Clk));
    checkOutput("rdvalid0", 64'(P0_RdValid), 64'(ev0));
    checkOutput("rdvalid1", 64'(P1_RdValid), 64'(ev1));
    checkOutput("dout0", 64'(P0_Dout), 64'(ed0));
    checkOutput("dout1", 64'(P1_Dout), 64'(ed1));

    if (w >= 0) begin
      last_win = w;
      if (wen[w] == '0) begin
        rdq.push_back('{owner: w, data: ref_mem[addr[w][7:0]], due: cyc + LAT});
      end else begin
        for (int b = 0; b < WW; b++)
          if (wen[w][b]) ref_mem[addr[w][7:0]][8*b +: 8] = din[w][8*b +: 8];
      end
    end
    if (!Rst && !inj_rst) begin
      if (holder >= 0) begin
        held++;
        if (!lock[holder]) holder = -1;
        else if (held >= MH) begin last_win = holder; holder = -1; end
      end else if (w >= 0 && lock[w]) begin
        holder = w; held = 1;
        if (held >= MH) holder = -1;
      end
    end
    model_win = w;
    cyc++;
  endtask

  task automatic applyStimulus(input bit rst, input bit inj,
                               input bit r0, input bit l0, input logic [AW-1:0] a0,
                               input logic [DW-1:0] d0, input logic [WW-1:0] w0,
                               input bit r1, input bit l1, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d1, input logic [WW-1:0] w1);
    Rst = rst; inj_rst = inj;
    P0_Req = r0; P0_Lock = l0; P0_Addr = a0; P0_Din = d0; P0_WEN = w0;
    P1_Req = r1; P1_Lock = l1; P1_Addr = a1; P1_Din = d1; P1_WEN = w1;
    @(negedge Clk);
    checkCycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  bit            pend [2];
  bit            rq [2], lk [2];
  logic [AW-1:0] ra [2];
  logic [DW-1:0] rd [2];
  logic [WW-1:0] rw [2];
  bit            rrst, rinj;

  initial begin
    compared = 0; mismatched = 0;
    holder = -1; held = 0; last_win = 1; cyc = 0; model_win = -1;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
    for (int i = 0; i < LAT; i++) pipe[i] = '0;

    // Reset, then both ports contend with reads.
    applyStimulus(1, 0, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
    applyStimulus(1, 0, 1, 0, 16'h1, '0, '0, 1, 0, 16'h2, '0, '0);
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 0, 1, 0, 16'(i), '0, '0, 1, 0, 16'(i + 4), '0, '0);
    idle(LAT + 1);

    // Write then read-back through the other port.
    applyStimulus(0, 0, 1, 0, 16'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, '0, '0, '0);
    applyStimulus(0, 0, 0, 0, '0, '0, '0, 1, 0, 16'h10, '0, '0);
    idle(LAT + 1);

    // Lock held past MAX_HOLD while P1 waits.
    for (int i = 0; i < 7; i++)
      applyStimulus(0, 0, 1, 1, 16'h20, '0, '0, 1, 0, 16'h21, '0, '0);
    idle(2);

    // Locked read then unlocking write; P1 must wait until after the write.
    applyStimulus(0, 0, 0, 0, '0, '0, '0, 1, 0, 16'h3, '0, '0);
    applyStimulus(0, 0, 1, 1, 16'h30, '0, '0, 1, 0, 16'h31, '0, '0);
    applyStimulus(0, 0, 1, 0, 16'h30, 32'h1234_5678, 4'h3, 1, 0, 16'h31, '0, '0);
    applyStimulus(0, 0, 0, 0, '0, '0, '0, 1, 0, 16'h31, '0, '0);
    idle(LAT + 1);

    // Reset one cycle after a read drops the data.
    applyStimulus(0, 0, 1, 0, 16'h10, '0, '0, 0, 0, '0, '0, '0);
    applyStimulus(1, 0, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
    idle(LAT + 2);

    // Injected BRAM reset while both request, then arbitration resumes.
    applyStimulus(0, 0, 1, 0, 16'h5, '0, '0, 0, 0, '0, '0, '0);
    for (int i = 0; i < 2; i++)
      applyStimulus(0, 1, 1, 0, 16'h6, '0, '0, 1, 0, 16'h7, '0, '0);
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 0, 1, 0, 16'h6, '0, '0, 1, 0, 16'h7, '0, '0);
    idle(LAT + 1);

    // Random traffic obeying the hold-until-granted protocol.
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n]) begin
          rq[n] = ($urandom_range(0, 99) < 60);
          ra[n] = 16'($urandom_range(0, 15));
          rd[n] = $urandom;
          rw[n] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
          pend[n] = rq[n];
        end
        lk[n] = ($urandom_range(0, 99) < 40);
      end
      rrst = ($urandom_range(0, 99) == 0);
      rinj = ($urandom_range(0, 59) == 0);
      applyStimulus(rrst, rinj, rq[0], lk[0], ra[0], rd[0], rw[0],
                    rq[1], lk[1], ra[1], rd[1], rw[1]);
      if (model_win >= 0) begin
        pend[model_win] = 0;
        rq[model_win] = 0;
      end
    end
    idle(LAT + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
